conv_stream_tx: RTL

//  Transmit end of the convolution datapath: takes one convolution result per cycle from the kernel MAC pipeline.

---
 rtl/conv_stream_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/conv_stream_tx.sv
// conv_stream_tx
//   Transmit end of the convolution datapath. Each convolution result from the
//   MAC pipeline is rounded (half-up), shifted and clamped to an unsigned pixel.
//   It is then buffered in a small FIFO and sent out as an AXI4-Stream image
//   with row (tlast) and frame (tuser) framing. The MAC pipeline cannot be
//   stalled: results arriving while the FIFO is full are dropped, and the
//   sticky overflow flag is raised.
// Ports
//   axi_clk, axi_rstn     clock, asynchronous active-low reset
//   conv_data/conv_valid  signed result stream in (no ready)
//   m_axis_t*             AXI4-Stream master out (tuser = first pixel of frame)
//   frame_done            1-cycle pulse after the last pixel of a frame is accepted
//   overflow              sticky drop indicator, cleared only by reset
module conv_stream_tx #(
  parameter int IMAGE_COLUMN     = 512,
  parameter int IMAGE_ROW        = 512,
  parameter int RESULT_WIDTH     = 24,
  parameter int IMAGE_DATA_WIDTH = 8,
  parameter int RESULT_SHIFT     = 8,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                           axi_clk,
  input  logic                           axi_rstn,
  input  logic signed [RESULT_WIDTH-1:0] conv_data,
  input  logic                           conv_valid,
  output logic [IMAGE_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  input  logic                           m_axis_tready,
  output logic                           frame_done,
  output logic                           overflow
);

  localparam int TW     = RESULT_WIDTH + 1;
  localparam int W      = IMAGE_DATA_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = (IMAGE_COLUMN > 1) ? $clog2(IMAGE_COLUMN) : 1;
  localparam int RWD    = (IMAGE_ROW > 1) ? $clog2(IMAGE_ROW) : 1;
  localparam int RSH_M1 = (RESULT_SHIFT > 0) ? RESULT_SHIFT - 1 : 0;
  localparam logic signed [TW-1:0] RND  = (RESULT_SHIFT > 0) ? (TW'(1) << RSH_M1) : '0;
  localparam logic signed [TW-1:0] PMAX = TW'((1 << IMAGE_DATA_WIDTH) - 1);

  // One extra bit of headroom means the rounding add can never wrap.
  function automatic logic signed [TW-1:0] round_add(input logic signed [RESULT_WIDTH-1:0] d);
    return $signed({d[RESULT_WIDTH-1], d}) + RND;
  endfunction

  function automatic logic [W-1:0] sat_pixel(input logic signed [TW-1:0] t);
    logic signed [TW-1:0] u;
    u = t >>> RESULT_SHIFT;
    if (u[TW-1])
      return '0;
    else if (u > PMAX)
      return '1;
    else
      return u[W-1:0];
  endfunction

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  logic signed [TW-1:0] t_p1;
  logic                 vld_p1;
  logic [W-1:0]         pix_p2;
  logic                 vld_p2;

  logic [W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, fifo_cnt;
  logic         fifo_empty, fifo_full, fifo_rd, fifo_wr, drop;

  out_state_t     state;
  logic [CW-1:0]  col, col_nx, tag_col;
  logic [RWD-1:0] row, row_nx, tag_row;
  logic           col_last, row_last, hs;

  // ---- stage p1: sign-extend and add rounding constant
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= conv_valid;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage p2: arithmetic shift and clamp to pixel range
  always_ff @(posedge axi_clk) begin
    t_p1   <= round_add(conv_data);
    pix_p2 <= sat_pixel(t_p1);
  end

  // ---- FIFO: pointers carry one wrap bit so full and empty are distinct
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_rd    = !fifo_empty && (!m_axis_tvalid || m_axis_tready);
  // A read in the same cycle frees a slot, so writing into a full FIFO is legal then.
  assign fifo_wr    = vld_p2 && (!fifo_full || fifo_rd);
  assign drop       = vld_p2 && fifo_full && !fifo_rd;

  always_ff @(posedge axi_clk) begin
    if (fifo_wr)
      fifo_mem[wr_ptr[AW-1:0]] <= pix_p2;
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      if (drop)    overflow <= 1'b1;
    end
  end

  // ---- output register and framing counters
  // col/row hold the position of the pixel in (or next into) the output register.
  // A reload during a handshake takes the position after the one being accepted.
  assign hs       = m_axis_tvalid && m_axis_tready;
  assign col_last = (col == CW'(IMAGE_COLUMN - 1));
  assign row_last = (row == RWD'(IMAGE_ROW - 1));
  assign col_nx   = col_last ? '0 : col + 1'b1;
  assign row_nx   = col_last ? (row_last ? '0 : row + 1'b1) : row;
  assign tag_col  = (state == OUT_FULL) ? col_nx : col;
  assign tag_row  = (state == OUT_FULL) ? row_nx : row;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state         <= OUT_EMPTY;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      col           <= '0;
      row           <= '0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= hs && col_last && row_last;
      if (hs) begin
        col <= col_nx;
        row <= row_nx;
      end
      case (state)
        OUT_EMPTY: begin
          if (!fifo_empty) begin
            state         <= OUT_FULL;
            m_axis_tvalid <= 1'b1;
          end
        end
        OUT_FULL: begin
          if (m_axis_tready && fifo_empty) begin
            state         <= OUT_EMPTY;
            m_axis_tvalid <= 1'b0;
          end
        end
        default: begin
          state         <= OUT_EMPTY;
          m_axis_tvalid <= 1'b0;
        end
      endcase
      if (fifo_rd) begin
        m_axis_tdata <= fifo_mem[rd_ptr[AW-1:0]];
        m_axis_tlast <= (tag_col == CW'(IMAGE_COLUMN - 1));
        m_axis_tuser <= (tag_col == '0) && (tag_row == '0);
      end
    end
  end

endmodule
